spi_flash_target: RTL

- SPI mode-0 target that emulates the subset of a serial NOR flash used by the USB bootloader's SPI master: JEDEC ID, status read, release-power-down, and sequential read.
- Sits in the board test harness and debug builds, on the far side of the bootloader's spi_cs/spi_sck/spi_mosi/spi_miso pins.
- Oversamples the SPI pins in the clk_48mhz domain.
- Serves read data from an external synchronous byte memory through a simple request port.

---
 rtl/spi_flash_target.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_target.sv
// rtl/spi_flash_target.sv - SPI mode-0 serial NOR flash emulator (JEDEC ID, status, RPD, read).
// SPI pins are oversampled in the clk_48mhz domain; read data comes from an external byte memory.
module spi_flash_target #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  DEV_ID   = 8'h15
) (
  input  logic              clk_48mhz,
  input  logic              reset_n,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STATUS, RPD, IGNORE} state_t;

  logic cs_s1_q, cs_s2_q, cs_d_q;
  logic sck_s1_q, sck_s2_q, sck_d_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [4:0]        addr_cnt_q, addr_cnt_d;
  logic [23:0]       rx_sr_q, rx_sr_d;
  logic [7:0]        tx_q, tx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              oe_q, oe_d;
  logic              mem_rd_q, mem_rd_d;
  logic              ld_q, ld_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic        sck_rise, sck_fall, cs_fall, cs_rise, byte_done;
  logic [23:0] rx_next;

  assign sck_rise  = sck_s2_q & ~sck_d_q;
  assign sck_fall  = ~sck_s2_q & sck_d_q;
  assign cs_fall   = ~cs_s2_q & cs_d_q;
  assign cs_rise   = cs_s2_q & ~cs_d_q;
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign rx_next   = {rx_sr_q[22:0], mosi_s2_q};

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_d_q     <= 1'b1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_d_q    <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      addr_cnt_q <= 5'd0;
      rx_sr_q    <= 24'd0;
      tx_q       <= 8'd0;
      byte_idx_q <= 2'd0;
      oe_q       <= 1'b0;
      mem_rd_q   <= 1'b0;
      ld_q       <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      cs_s1_q    <= spi_cs;
      cs_s2_q    <= cs_s1_q;
      cs_d_q     <= cs_s2_q;
      sck_s1_q   <= spi_sck;
      sck_s2_q   <= sck_s1_q;
      sck_d_q    <= sck_s2_q;
      mosi_s1_q  <= spi_mosi;
      mosi_s2_q  <= mosi_s1_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_q       <= tx_d;
      byte_idx_q <= byte_idx_d;
      oe_q       <= oe_d;
      mem_rd_q   <= mem_rd_d;
      ld_q       <= ld_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    addr_cnt_d = addr_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_d       = tx_q;
    byte_idx_d = byte_idx_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    ld_d       = mem_rd_q & ~cs_rise;

    if (cs_rise) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      addr_cnt_d = 5'd0;
      tx_d       = 8'd0;
    end else begin
      if (sck_rise && state_q != IDLE) begin
        rx_sr_d   = rx_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      // The fall that ends a byte must not shift: the freshly loaded MSB has to survive it.
      if (sck_fall && bit_cnt_q != 3'd0)
        tx_d = {tx_q[6:0], 1'b0};

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d    = CMD;
            bit_cnt_d  = 3'd0;
            addr_cnt_d = 5'd0;
            tx_d       = 8'd0;
          end
        end
        CMD: begin
          if (byte_done) begin
            case (rx_next[7:0])
              8'h9F: begin state_d = ID;     tx_d = JEDEC_ID[23:16]; byte_idx_d = 2'd1; end
              8'h05: begin state_d = STATUS; tx_d = 8'h00; end
              8'hAB: begin state_d = RPD;    tx_d = 8'h00; byte_idx_d = 2'd0; end
              8'h03: begin state_d = ADDR;   addr_cnt_d = 5'd0; end
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_cnt_d = addr_cnt_q + 5'd1;
            if (addr_cnt_q == 5'd23) begin
              mem_addr_d = rx_next[ADDR_W-1:0];
              mem_rd_d   = 1'b1;
              tx_d       = 8'd0;
              state_d    = DATA;
            end
          end
        end
        DATA: begin
          if (ld_q)
            tx_d = mem_rdata;
          if (byte_done) begin
            mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            mem_rd_d   = 1'b1;
          end
        end
        ID: begin
          if (byte_done) begin
            case (byte_idx_q)
              2'd1:    tx_d = JEDEC_ID[15:8];
              2'd2:    tx_d = JEDEC_ID[7:0];
              default: tx_d = 8'h00;
            endcase
            if (byte_idx_q != 2'd3)
              byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        STATUS: begin
          if (byte_done)
            tx_d = 8'h00;
        end
        RPD: begin
          // byte_idx counts the three dummy bytes, then parks at 3 while DEV_ID repeats.
          if (byte_done) begin
            if (byte_idx_q >= 2'd2) begin
              tx_d       = DEV_ID;
              byte_idx_d = 2'd3;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end

    oe_d = (state_d inside {ID, STATUS, DATA}) || (state_d == RPD && byte_idx_d == 2'd3);
  end

  assign spi_miso    = oe_q & tx_q[7];
  assign spi_miso_oe = oe_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = (state_q != IDLE);

endmodule
